rng_health_buffer: RTL and testbench

RNG_HEALTH_BUFFER -- requirements
Module: rng_health_buffer

---
 rtl/rng_health_buffer_pkg.sv | 27 ++
 rtl/rng_health_buffer_if.sv | 24 ++
 rtl/sync_fifo_ptr.sv | 78 +++++++
 rtl/rng_health_buffer.sv | 137 +++++++++++++
 tb/tb_rng_health_buffer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rng_health_buffer_pkg.sv
// Shared definitions for the RNG health-test buffer.
//   - FSM state encoding (STARTUP / RUN / ALARM)
//   - Default health-test constants (FIFO depth, APT window and bounds,
//     RCT cutoff)
//   - popcount16(): number of ones in a 16-bit word
package rng_health_buffer_pkg;

  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_ALARM   = 2'd2;

  localparam int DEF_DEPTH      = 4;
  localparam int DEF_WINDOW     = 64;
  localparam int DEF_APT_LO     = 432;
  localparam int DEF_APT_HI     = 592;
  localparam int DEF_RCT_CUTOFF = 34;

  function automatic logic [4:0] popcount16(input logic [15:0] w);
    logic [4:0] sum;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum = sum + {4'b0, w[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/rng_health_buffer_if.sv
// Word-stream interface of the RNG health-test buffer.
//   in_valid  : word strobe from the 16-bit packer (no backpressure)
//   in_word   : packed random bits, bit 0 oldest
//   out_valid : FIFO head valid
//   out_ready : consumer accepts the head word
//   out_word  : FIFO head data
// The master modport is the packer/consumer side, slave is the buffer.
interface rng_health_buffer_if;
  logic        in_valid;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;

  modport master (
    output in_valid, in_word, out_ready,
    input  out_valid, out_word
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output out_valid, out_word
  );
endinterface

// File: rtl/sync_fifo_ptr.sv
// Synchronous pointer-based FIFO for the health buffer output.
//   clk, reset   : clock, synchronous active-high reset
//   flush_i      : drop all contents (pointers/occupancy cleared)
//   push_i       : write data_i this cycle
//   data_i       : write data
//   ready_i      : consumer ready; a pop happens when valid_o & ready_i
//   valid_o      : FIFO non-empty
//   data_o       : head word (0 when empty)
//   occupancy_o  : number of stored words
//   overflow_o   : sticky flag, set when a push is dropped
module sync_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic             overflow_q;

  logic full, pop, accept;

  assign full   = (count_q == OCC_W'(DEPTH));
  assign pop    = valid_o && ready_i;
  // A push into a full FIFO only fits if the head leaves on the same edge.
  assign accept = push_i && (!full || pop);

  assign valid_o     = (count_q != '0);
  assign data_o      = valid_o ? mem_q[rd_ptr_q] : '0;
  assign occupancy_o = count_q;
  assign overflow_o  = overflow_q;

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are PTR_W bits wide, so they wrap modulo DEPTH naturally.
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_i && !accept) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through data_o, which is gated by valid_o, so stale data never leaks.
  always_ff @(posedge clk) begin
    if (accept && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rng_health_buffer.sv
// RNG health-test buffer.
// Runs a repetition-count test (RCT) and an adaptive-proportion test (APT)
// on every sampled 16-bit word. After a first passing window the FSM moves
// from STARTUP to RUN and passing words are buffered in a small FIFO. Any
// test failure latches ALARM, flushes the FIFO and freezes the tests until
// reset.
//   clk, reset : clock, synchronous active-high reset
//   bus        : word stream in / FIFO head out (slave modport)
//   alarm      : sticky health failure (state == ALARM)
//   overflow   : sticky dropped-word flag
//   occupancy  : FIFO fill level
//   state      : FSM state (STARTUP=0, RUN=1, ALARM=2)
module rng_health_buffer
  import rng_health_buffer_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int APT_LO     = DEF_APT_LO,
  parameter int APT_HI     = DEF_APT_HI,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic                   clk,
  input  logic                   reset,
  rng_health_buffer_if.slave     bus,
  output logic                   alarm,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [1:0]             state
);

  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
  localparam int ACC_W = $clog2(WINDOW * 16 + 1);
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [1:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sample, rct_fail, apt_fail, fail, window_end, push;
  logic [ACC_W-1:0] total;

  // Tests are frozen once the alarm has latched.
  assign sample = bus.in_valid && (state_q != ST_ALARM);
  assign total  = acc_q + ACC_W'(popcount16(bus.in_word));

  // NOTE: every signal written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    run_d      = run_q;
    last_d     = last_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rct_fail   = 1'b0;
    apt_fail   = 1'b0;
    window_end = 1'b0;
    if (sample) begin
      // Bit-serial run tracking, oldest bit first. After reset run=0, so the
      // first bit always yields run=1 whatever last_q holds.
      for (int i = 0; i < 16; i++) begin
        if (bus.in_word[i] == last_d) begin
          if (run_d != RUN_W'(RCT_CUTOFF)) run_d = run_d + RUN_W'(1);
        end else begin
          run_d = RUN_W'(1);
        end
        last_d = bus.in_word[i];
        if (run_d == RUN_W'(RCT_CUTOFF)) rct_fail = 1'b1;
      end

      window_end = (cnt_q == CNT_W'(WINDOW - 1));
      apt_fail   = window_end &&
                   ((total < ACC_W'(APT_LO)) || (total > ACC_W'(APT_HI)));
      acc_d      = window_end ? '0 : total;
      cnt_d      = window_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign fail = rct_fail || apt_fail;
  assign push = sample && (state_q == ST_RUN) && !fail;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STARTUP: begin
        if (fail)                     state_d = ST_ALARM;
        else if (sample && window_end) state_d = ST_RUN;
      end
      ST_RUN:   if (fail) state_d = ST_ALARM;
      ST_ALARM: state_d = ST_ALARM;
      default:  state_d = ST_ALARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STARTUP;
      run_q   <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  logic        fifo_valid;
  logic [15:0] fifo_data;

  // The failing word is never pushed and the FIFO is flushed on the same
  // edge that latches ALARM.
  sync_fifo_ptr #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (fail),
    .push_i      (push),
    .data_i      (bus.in_word),
    .ready_i     (bus.out_ready),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .occupancy_o (occupancy),
    .overflow_o  (overflow)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_word  = fifo_data;
  assign alarm         = (state_q == ST_ALARM);
  assign state         = state_q;

endmodule

// File: tb/tb_rng_health_buffer.sv
// Self-checking bench for rng_health_buffer: directed table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_rng_health_buffer;

  localparam int DEPTH  = 4;
  localparam int WINDOW = 64;
  localparam int APT_LO = 432;
  localparam int APT_HI = 592;
  localparam int CUT    = 34;

  logic       clk = 1'b0;
  logic       reset;
  logic       alarm, overflow;
  logic [2:0] occupancy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  rng_health_buffer_if bus_if ();

  rng_health_buffer #(
    .DEPTH (DEPTH), .WINDOW (WINDOW), .APT_LO (APT_LO),
    .APT_HI (APT_HI), .RCT_CUTOFF (CUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .alarm     (alarm),
    .overflow  (overflow),
    .occupancy (occupancy),
    .state     (state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_state;   // 0 startup, 1 run, 2 alarm
  int          m_run;     // 0 = no bit seen since reset
  bit          m_last;
  int          m_ones, m_words;
  logic [15:0] m_q[$];
  bit          m_ovf;

  task automatic model_reset();
    m_state = 0; m_run = 0; m_last = 1'b0;
    m_ones = 0; m_words = 0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [15:0] w, input bit r);
    bit pop, rct_bad, apt_bad, wend;
    int old_state;
    pop = (m_q.size() > 0) && r;
    if (v && m_state != 2) begin
      old_state = m_state;
      rct_bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (m_run > 0 && w[i] == m_last) m_run = (m_run + 1 > CUT) ? CUT : m_run + 1;
        else m_run = 1;
        m_last = w[i];
        if (m_run >= CUT) rct_bad = 1'b1;
      end
      m_ones  += $countones(w);
      m_words += 1;
      wend    = (m_words == WINDOW);
      apt_bad = wend && (m_ones < APT_LO || m_ones > APT_HI);
      if (wend) begin m_ones = 0; m_words = 0; end
      if (rct_bad || apt_bad) begin
        m_state = 2;
        m_q.delete();
        return;
      end
      if (wend && old_state == 0) m_state = 1;
      if (pop) void'(m_q.pop_front());
      if (old_state == 1) begin
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1'b1;
      end
    end else if (pop) begin
      void'(m_q.pop_front());
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_state",     32'(state), 32'(m_state));
    check("m_alarm",     32'(alarm), 32'(m_state == 2));
    check("m_overflow",  32'(overflow), 32'(m_ovf));
    check("m_occupancy", 32'(occupancy), 32'(m_q.size()));
    check("m_out_valid", 32'(bus_if.out_valid), 32'(m_q.size() > 0));
    check("m_out_word",  32'(bus_if.out_word), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
  endtask

  // Drive one cycle of inputs (called at a negedge), sample at next negedge.
  task automatic step(input bit v, input logic [15:0] w, input bit r);
    bus_if.in_valid  = v;
    bus_if.in_word   = w;
    bus_if.out_ready = r;
    model_step(v, w, r);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset(input bit v, input logic [15:0] w);
    reset            = 1'b1;
    bus_if.in_valid  = v;
    bus_if.in_word   = w;
    bus_if.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_if.in_valid = 1'b0;
    model_reset();
    check("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
    check("rst_out_word",  32'(bus_if.out_word), 32'h0);
    check("rst_alarm",     32'(alarm), 32'h0);
    check("rst_overflow",  32'(overflow), 32'h0);
    check("rst_occupancy", 32'(occupancy), 32'h0);
    check("rst_state",     32'(state), 32'h0);
  endtask

  // A full passing window of A5A5 (512 ones, max run 2) reaches RUN exactly
  // after the WINDOW-th word.
  task automatic run_window();
    for (int i = 0; i < WINDOW; i++) begin
      step(1'b1, 16'hA5A5, 1'b0);
      if (i == WINDOW - 2) check("win_not_yet_run", 32'(state), 32'h0);
      if (i == WINDOW - 1) check("win_run",         32'(state), 32'h1);
    end
  endtask

  typedef struct {
    bit          v;
    logic [15:0] w;
    bit          r;
    bit          ov;
    logic [15:0] ow;
    int          occ;
    bit          ovf;
  } vec_t;

  vec_t        tbl[12];
  logic [15:0] exp_order[7];

  initial begin
    tbl[0]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 16'h1234, 2, 1'b0};
    tbl[1]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 16'h1234, 3, 1'b0};
    tbl[2]  = '{1'b1, 16'h3333, 1'b0, 1'b1, 16'h1234, 4, 1'b0};
    tbl[3]  = '{1'b1, 16'h4444, 1'b0, 1'b1, 16'h1234, 4, 1'b1};
    tbl[4]  = '{1'b1, 16'h5555, 1'b1, 1'b1, 16'h1111, 4, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222, 3, 1'b1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222, 3, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h3333, 2, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h5555, 1, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1};
    tbl[10] = '{1'b1, 16'h00FF, 1'b1, 1'b1, 16'h00FF, 1, 1'b1};
    tbl[11] = '{1'b1, 16'hFF00, 1'b1, 1'b1, 16'hFF00, 1, 1'b1};

    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_word   = '0;
    bus_if.out_ready = 1'b0;
    model_reset();

    // Startup window, then first stored word visible one cycle later.
    do_reset(1'b0, 16'h0000);
    run_window();
    step(1'b1, 16'h1234, 1'b0);
    check("first_out_valid", 32'(bus_if.out_valid), 32'h1);
    check("first_out_word",  32'(bus_if.out_word), 32'h1234);
    check("first_occ",       32'(occupancy), 32'h1);

    // Table: fill to full with overflow, then drain and pass-through.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].r);
      check($sformatf("tbl%0d_out_valid", i), 32'(bus_if.out_valid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_out_word", i),  32'(bus_if.out_word), 32'(tbl[i].ow));
      check($sformatf("tbl%0d_occ", i),       32'(occupancy), 32'(tbl[i].occ));
      check($sformatf("tbl%0d_ovf", i),       32'(overflow), 32'(tbl[i].ovf));
      check($sformatf("tbl%0d_state", i),     32'(state), 32'h1);
    end

    // RCT failure in RUN: run reaches 34 inside 16'h0003.
    do_reset(1'b0, 16'h0000);
    run_window();
    step(1'b1, 16'h1234, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    check("rct_pre_alarm", 32'(alarm), 32'h0);
    check("rct_pre_occ",   32'(occupancy), 32'h3);
    step(1'b1, 16'h0003, 1'b0);
    check("rct_alarm",     32'(alarm), 32'h1);
    check("rct_state",     32'(state), 32'h2);
    check("rct_out_valid", 32'(bus_if.out_valid), 32'h0);
    check("rct_occ",       32'(occupancy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'h0003, 1'b1);
      check("alarm_no_output", 32'(bus_if.out_valid), 32'h0);
      check("alarm_held",      32'(alarm), 32'h1);
    end

    // Reset out of ALARM (in_valid high in the reset cycle is ignored);
    // the window must restart from zero.
    do_reset(1'b1, 16'hFFFF);
    run_window();

    // Reset mid-window discards the partial window.
    do_reset(1'b0, 16'h0000);
    for (int i = 0; i < 30; i++) step(1'b1, 16'hA5A5, 1'b0);
    do_reset(1'b1, 16'hA5A5);
    run_window();

    // APT failure in STARTUP: 128 ones per window.
    do_reset(1'b0, 16'h0000);
    for (int i = 0; i < WINDOW; i++) begin
      step(1'b1, 16'h0101, 1'b0);
      if (i < WINDOW - 1) check("apt_startup_state", 32'(state), 32'h0);
    end
    check("apt_alarm", 32'(alarm), 32'h1);
    check("apt_state", 32'(state), 32'h2);

    // Full FIFO with simultaneous push and pop: no overflow, order kept.
    do_reset(1'b0, 16'h0000);
    run_window();
    step(1'b1, 16'h1111, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    step(1'b1, 16'h3333, 1'b0);
    step(1'b1, 16'h4444, 1'b0);
    check("full_occ", 32'(occupancy), 32'h4);
    check("full_ovf", 32'(overflow), 32'h0);
    exp_order = '{16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h0000};
    step(1'b1, 16'h5555, 1'b1);
    check("pp0_occ", 32'(occupancy), 32'h4);
    check("pp0_ovf", 32'(overflow), 32'h0);
    check("pp0_word", 32'(bus_if.out_word), 32'(exp_order[0]));
    step(1'b1, 16'h6666, 1'b1);
    check("pp1_occ", 32'(occupancy), 32'h4);
    check("pp1_word", 32'(bus_if.out_word), 32'(exp_order[1]));
    step(1'b1, 16'h7777, 1'b1);
    check("pp2_occ", 32'(occupancy), 32'h4);
    check("pp2_ovf", 32'(overflow), 32'h0);
    check("pp2_word", 32'(bus_if.out_word), 32'(exp_order[2]));
    for (int i = 3; i < 7; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      check($sformatf("drain%0d_word", i), 32'(bus_if.out_word), 32'(exp_order[i]));
    end

    // Randomized traffic against the model; later segments inject more
    // all-ones / all-zeros words to provoke RCT alarms.
    for (int seg = 0; seg < 5; seg++) begin
      do_reset(1'b0, 16'h0000);
      for (int n = 0; n < 400; n++) begin
        logic [15:0] w;
        int          pick;
        pick = $urandom_range(0, 99);
        if (pick < seg * 3)          w = 16'hFFFF;
        else if (pick < seg * 5)     w = 16'h0000;
        else                         w = 16'($urandom);
        step($urandom_range(0, 3) != 0, w, $urandom_range(0, 1) == 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
